// File: rtl/sprite_regfile_pkg.sv
// Shared constants for the double-buffered sprite descriptor store:
// control-register offsets, status bit positions and the commit state type.
package sprite_regfile_pkg;

    localparam int FRAME_W = 32;

    localparam int OFS_COMMIT = 0;
    localparam int OFS_CLEAR  = 1;
    localparam int OFS_FRAME  = 2;
    localparam int OFS_IRQ    = 3;

    localparam int ST_PENDING = 0;
    localparam int ST_VBLANK  = 1;
    localparam int ST_IRQ     = 2;

    typedef enum logic {
        CP_IDLE    = 1'b0,
        CP_PENDING = 1'b1
    } commit_state_e;

    // Index width that stays legal for a single-slot bank.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_regfile_bank.sv
// NUM_SPRITES x DATA_W descriptor array with a write port, bulk clear/load
// and a registered, bounds-checked read port. Load takes priority over clear and write.
module sprite_bank
    import sprite_regfile_pkg::*;
#(
    parameter int NUM_SPRITES = 30,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = idx_width(NUM_SPRITES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          clr,
    input  logic                          load,
    input  logic [NUM_SPRITES*DATA_W-1:0] load_data,
    input  logic                          rd_en,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [DATA_W-1:0]             rd_data,
    output logic [NUM_SPRITES*DATA_W-1:0] mem_flat
);

    logic [DATA_W-1:0] mem_q [NUM_SPRITES];
    logic [DATA_W-1:0] mem_d [NUM_SPRITES];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            mem_d[i] = mem_q[i];
            if (load) begin
                mem_d[i] = load_data[i*DATA_W +: DATA_W];
            end else if (clr) begin
                mem_d[i] = '0;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    // Out-of-range indices match no slot and read back as zero.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data_d = mem_q[i];
                end
            end
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_regfile.sv
// Double-buffered sprite descriptor store: CPU writes the shadow bank, the
// display reads the active bank, copied atomically on vblank rise. IRQ via SPRITE_REGFILE_IRQ_EN.
//
// commit_q     | meaning
// CP_IDLE      | active bank is current, nothing queued
// CP_PENDING   | COMMIT written, copy happens at next vblank rise
module sprite_regfile
    import sprite_regfile_pkg::*;
#(
    parameter int NUM_SPRITES = 30,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 chipselect,
    input  logic                                 write,
    input  logic                                 read,
    input  logic [ADDR_W-1:0]                    address,
    input  logic [DATA_W-1:0]                    writedata,
    output logic [DATA_W-1:0]                    readdata,
    input  logic                                 vblank,
    input  logic [idx_width(NUM_SPRITES)-1:0]    disp_idx,
    output logic [DATA_W-1:0]                    disp_data
`ifdef SPRITE_REGFILE_IRQ_EN
    ,
    output logic                                 irq
`endif
);

    localparam int IDX_W = idx_width(NUM_SPRITES);
    localparam logic [ADDR_W-1:0] CTRL     = ADDR_W'(2**ADDR_W - 4);
    localparam logic [ADDR_W-1:0] A_COMMIT = CTRL + ADDR_W'(OFS_COMMIT);
    localparam logic [ADDR_W-1:0] A_CLEAR  = CTRL + ADDR_W'(OFS_CLEAR);
    localparam logic [ADDR_W-1:0] A_FRAME  = CTRL + ADDR_W'(OFS_FRAME);
    localparam logic [ADDR_W-1:0] A_IRQ    = CTRL + ADDR_W'(OFS_IRQ);

    logic                          wr_acc, rd_acc, slot_hit;
    logic                          vblank_q, vblank_d, vblank_rise, copy;
    commit_state_e                 commit_q, commit_d;
    logic [FRAME_W-1:0]            frame_q, frame_d;
    logic                          rd_bank_q, rd_bank_d;
    logic [DATA_W-1:0]             ctrl_rd_q, ctrl_rd_d;
    logic [2:0]                    status;
    logic                          irq_pend;
    logic [DATA_W-1:0]             shadow_rd;
    logic [NUM_SPRITES*DATA_W-1:0] shadow_flat;
    logic [NUM_SPRITES*DATA_W-1:0] active_flat_unused;

    assign wr_acc   = chipselect & write;
    assign rd_acc   = chipselect & read;
    assign slot_hit = (address < ADDR_W'(NUM_SPRITES));

    always_comb begin
        vblank_d    = vblank;
        vblank_rise = vblank & ~vblank_q;
        copy        = vblank_rise && (commit_q == CP_PENDING);

        // A COMMIT landing in the copy cycle re-arms for the next frame.
        commit_d = commit_q;
        if (copy) begin
            commit_d = CP_IDLE;
        end
        if (wr_acc && (address == A_COMMIT)) begin
            commit_d = CP_PENDING;
        end

        frame_d = vblank_rise ? frame_q + FRAME_W'(1) : frame_q;

        status              = '0;
        status[ST_PENDING]  = (commit_q == CP_PENDING);
        status[ST_VBLANK]   = vblank;
        status[ST_IRQ]      = irq_pend;

        rd_bank_d = rd_bank_q;
        ctrl_rd_d = ctrl_rd_q;
        if (rd_acc) begin
            rd_bank_d = slot_hit;
            case (address)
                A_COMMIT: ctrl_rd_d = DATA_W'(status);
                A_FRAME:  ctrl_rd_d = DATA_W'(frame_q);
                A_IRQ:    ctrl_rd_d = DATA_W'(irq_pend);
                default:  ctrl_rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q  <= 1'b0;
            commit_q  <= CP_IDLE;
            frame_q   <= '0;
            rd_bank_q <= 1'b0;
            ctrl_rd_q <= '0;
        end else begin
            vblank_q  <= vblank_d;
            commit_q  <= commit_d;
            frame_q   <= frame_d;
            rd_bank_q <= rd_bank_d;
            ctrl_rd_q <= ctrl_rd_d;
        end
    end

`ifdef SPRITE_REGFILE_IRQ_EN
    logic irq_pend_q, irq_pend_d;

    // Set beats ack so a frame start is never lost.
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (wr_acc && (address == A_IRQ) && writedata[0]) begin
            irq_pend_d = 1'b0;
        end
        if (vblank_rise) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pend_q <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_pend = irq_pend_q;
    assign irq      = irq_pend_q;
`else
    assign irq_pend = 1'b0;
`endif

    sprite_bank #(
        .NUM_SPRITES (NUM_SPRITES),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_shadow (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_acc & slot_hit),
        .wr_idx    (address[IDX_W-1:0]),
        .wr_data   (writedata),
        .clr       (wr_acc && (address == A_CLEAR)),
        .load      (1'b0),
        .load_data ('0),
        .rd_en     (rd_acc & slot_hit),
        .rd_idx    (address[IDX_W-1:0]),
        .rd_data   (shadow_rd),
        .mem_flat  (shadow_flat)
    );

    sprite_bank #(
        .NUM_SPRITES (NUM_SPRITES),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_active (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .clr       (1'b0),
        .load      (copy),
        .load_data (shadow_flat),
        .rd_en     (1'b1),
        .rd_idx    (disp_idx),
        .rd_data   (disp_data),
        .mem_flat  (active_flat_unused)
    );

    // Slot reads come from the shadow bank's read register, control reads from ctrl_rd_q.
    assign readdata = rd_bank_q ? shadow_rd : ctrl_rd_q;

endmodule

// File: doc/sprite_regfile.md
# sprite_regfile

Parametrised, double-buffered sprite descriptor store for the VGA sprite pipeline. Sits between the Avalon-MM slave port and the sprite controller. The CPU writes descriptors into a shadow bank. The active bank that the display reads is updated atomically at the start of vertical blanking, so a frame never shows a half-updated sprite set. It also adds a bank clear, a status/frame counter readback and a vblank interrupt.

## Interface
Parameters:
- NUM_SPRITES, 30, number of descriptor slots; must be ≤ 2**ADDR_W − 4
- DATA_W, 32, descriptor width in bits (≥ 8)
- ADDR_W, 6, Avalon word-address width

Ports:
- clk  in  1  system clock; the single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  ADDR_W  Avalon word address
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- vblank  in  1  level, high during vertical blanking, synchronous to clk
- disp_idx  in  $clog2(NUM_SPRITES)  display-side slot select
- disp_data  out  DATA_W  active-bank descriptor for disp_idx
- irq  out  1  vblank interrupt (present only with SPRITE_REGFILE_IRQ_EN)

## Operation
- Address map: 0..NUM_SPRITES−1 are the shadow slots (read/write). CTRL = 2**ADDR_W − 4.
  - CTRL+0, COMMIT. A write sets commit_pending. A read returns {0…, irq_pend, vblank, commit_pending}.
  - CTRL+1, CLEAR. A write zeroes every shadow slot. A read returns 0.
  - CTRL+2, FRAME. Read-only 32-bit frame counter, zero-extended or truncated to DATA_W. Writes are ignored.
  - CTRL+3, IRQ. A write with bit0 = 1 acknowledges. A read returns irq_pend.
  - Every other address: writes are ignored and reads return 0.
- Access qualification: an access happens only when chipselect is high. If read and write are both high, the write is performed and readdata still updates with the pre-write value.
- vblank_rise = vblank & ~vblank_q, where vblank_q is a register.
- On vblank_rise:
  - frame counter increments, wrapping at 2**32 − 1 → 0
  - if commit_pending was set before this cycle, all shadow slots are copied to the active bank and commit_pending clears
- Same-cycle rules:
  - Shadow write or CLEAR in the copy cycle: the copy takes the pre-write values; the write or clear lands in shadow only.
  - COMMIT write in a vblank_rise cycle: pending ends up set and is applied at the next vblank_rise.
- Display read: disp_data is registered from active[disp_idx]. An out-of-range index returns 0.
- There is no state machine beyond commit_pending (IDLE/PENDING): COMMIT write moves IDLE→PENDING; vblank_rise while PENDING moves back to IDLE.

## Timing
- Reset (asynchronous, any time, including mid-frame): all shadow and active slots, readdata, disp_data, vblank_q, commit_pending, frame counter and irq_pend go to 0.
- Read latency is 1: readdata is valid in the cycle after read && chipselect, and holds its value otherwise.
- A write takes effect at the clock edge. A read of the same slot in the next cycle returns the new value.
- Active bank update: visible on disp_data 2 cycles after the vblank_rise cycle (1 cycle for the copy, 1 for the output register).
- disp_idx → disp_data latency is 1 cycle.

## Configuration
- SPRITE_REGFILE_IRQ_EN, when defined:
  - irq_pend sets on vblank_rise and clears on an IRQ ack write; set wins when both happen in the same cycle
  - irq = irq_pend, registered
- When not defined:
  - no irq port
  - irq_pend is tied to 0
  - CTRL+3 reads 0 and writes are ignored

## Structure
- Package sprite_regfile_pkg holds:
  - control offsets (OFS_COMMIT = 0, OFS_CLEAR = 1, OFS_FRAME = 2, OFS_IRQ = 3)
  - status bit indices (ST_PENDING = 0, ST_VBLANK = 1, ST_IRQ = 2)
  - FRAME_W = 32
- Sub-module sprite_bank: a NUM_SPRITES × DATA_W register array with a write port, a bulk clear/load, and a registered bounds-checked read. It is instantiated twice, once for shadow and once for active.

## Test plan
- Reset, then read slot 0, FRAME and COMMIT: each returns 0. disp_data = 0 and irq = 0.
- Write 0xDEADBEEF to slot 5 with no commit, pulse vblank: disp_idx = 5 gives 0. Reading slot 5 gives 0xDEADBEEF. FRAME reads 1.
- Write slot 5, write COMMIT, raise vblank: COMMIT reads pending = 1 before the edge and 0 after. disp_data = 0xDEADBEEF two cycles after vblank_rise.
- Write COMMIT and write slot 2 = 0x1234 in the vblank_rise cycle: the active bank keeps its old slot 2. After the next commit and vblank, disp_data = 0x1234.
- CLEAR after loading all slots, then COMMIT and vblank: every active slot is 0 and out-of-range disp_idx gives 0. Force the frame counter to 0xFFFFFFFF and pulse vblank: FRAME reads 0.
- With SPRITE_REGFILE_IRQ_EN defined: vblank_rise sets irq. An ack write clears it. An ack in a vblank_rise cycle leaves irq = 1. Asserting reset_n low mid-frame immediately clears irq and commit_pending.
